// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply and divide units.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package mult_div_pkg;

   // Control states shared by the multiplier and divider sequencers.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Radix-4 Booth iterations for a 32x32 multiply.
   localparam int MULT_STEPS = 16;

   // Radix-2 iterations for a 32-bit divide.
   localparam int DIV_STEPS = 32;

   // Booth digit selected from a 3-bit window of the multiplier.
   typedef enum logic [2:0] {
      BD_ZERO = 3'd0,
      BD_POS1 = 3'd1,
      BD_POS2 = 3'd2,
      BD_NEG1 = 3'd3,
      BD_NEG2 = 3'd4
   } booth_dig_t;

   // Window is {b[i+1], b[i], b[i-1]}; digit = -2*b[i+1] + b[i] + b[i-1].
   function automatic booth_dig_t booth_recode(input logic [2:0] win);
      booth_dig_t d;
      case (win)
         3'b001, 3'b010: d = BD_POS1;
         3'b011:         d = BD_POS2;
         3'b100:         d = BD_NEG2;
         3'b101, 3'b110: d = BD_NEG1;
         default:        d = BD_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Booth partial-product select: maps a 3-bit window and multiplicand M to an addend.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: bits = P[2:0] window, m = sign-extended multiplicand,
//        pp = addend (already inverted for negative digits), cin = adder carry-in.
module booth_pp_select
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [2:0]       bits,
   input  logic [WIDTH+1:0] m,
   output logic [WIDTH+1:0] pp,
   output logic             cin
);

   booth_dig_t       dig;
   logic [WIDTH+1:0] m2;

   // M is sign-extended by two bits, so 2M fits without losing the sign.
   assign m2 = {m[WIDTH:0], 1'b0};

   always_comb begin
      dig = booth_recode(bits);
      pp  = '0;
      cin = 1'b0;
      case (dig)
         BD_POS1: pp = m;
         BD_POS2: pp = m2;
         // Negation is ~x here plus the +1 carried into the shared adder.
         BD_NEG1: begin pp = ~m;  cin = 1'b1; end
         BD_NEG2: begin pp = ~m2; cin = 1'b1; end
         default: begin pp = '0;  cin = 1'b0; end
      endcase
   end

endmodule

// File: rtl/multiplier_booth.sv
// Iterative signed radix-4 Booth multiplier: low WIDTH bits of product plus overflow flag.
// Latency: 16 cycles from the start edge to the one-cycle ready pulse.
// Backpressure: none; start is accepted in any state and aborts an operation in flight.
// Ports: clock, reset (async, active-high), start, A_in (multiplicand), B_in (multiplier),
//        out (product low bits), exp (product does not fit in WIDTH signed bits), ready.
module multiplier_booth
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEPS = MULT_STEPS
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic [WIDTH-1:0] out,
   output logic             exp,
   output logic             ready
);

   localparam int MW = WIDTH + 2;        // multiplicand / adder width
   localparam int PW = 2 * WIDTH + 2;    // accumulator width
   localparam int CW = $clog2(STEPS);

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  cnt;
   logic           last_step;
   logic [MW-1:0]  m_reg;
   logic [PW-1:0]  p_reg;
   logic [PW-1:0]  p_nxt;
   logic [MW-1:0]  pp;
   logic           pp_cin;
   logic [MW-1:0]  acc_sum;
   logic [WIDTH:0] prod_hi;
   logic           ovf;

   booth_pp_select #(.WIDTH(WIDTH)) u_pp_select (
      .bits (p_reg[2:0]),
      .m    (m_reg),
      .pp   (pp),
      .cin  (pp_cin)
   );

   // Single adder: upper accumulator half, sign-extended, plus the selected addend.
   assign acc_sum = {p_reg[PW-1], p_reg[PW-1:WIDTH+1]} + pp + MW'(pp_cin);

   // Arithmetic shift right by 2; the low bit dropped from the old P is the
   // window bit already consumed.
   assign p_nxt = {acc_sum[MW-1], acc_sum, p_reg[WIDTH:2]};

   assign last_step = (cnt == CW'(STEPS - 1));

   // Product is P[2W:1]; its top W+1 bits must be all-equal for the result to fit.
   assign prod_hi = p_nxt[2*WIDTH:WIDTH];
   assign ovf     = (|prod_hi) && !(&prod_hi);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; start wins in every state.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ST_BUSY;
      end else begin
         case (state)
            ST_BUSY: if (last_step) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   // Output decode.
   always_comb begin
      ready = 1'b0;
      if (state == ST_DONE) ready = 1'b1;
   end

   // Datapath: operand load, iteration, and result capture on the final step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_reg <= '0;
         p_reg <= '0;
         cnt   <= '0;
         out   <= '0;
         exp   <= 1'b0;
      end else if (start) begin
         m_reg <= {A_in[WIDTH-1], A_in[WIDTH-1], A_in};
         p_reg <= {{(WIDTH+1){1'b0}}, B_in, 1'b0};
         cnt   <= '0;
      end else if (state == ST_BUSY) begin
         p_reg <= p_nxt;
         cnt   <= cnt + 1'b1;
         if (last_step) begin
            out <= p_nxt[WIDTH:1];
            exp <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_multiplier_booth.sv
module tb_multiplier_booth;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] A_in;
   logic [31:0] B_in;
   logic [31:0] out;
   logic        exp;
   logic        ready;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   multiplier_booth #(.WIDTH(32), .STEPS(16)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .A_in  (A_in),
      .B_in  (B_in),
      .out   (out),
      .exp   (exp),
      .ready (ready)
   );

   // Reference: full signed product with plain integer arithmetic.
   function automatic longint ref_prod(input logic [31:0] a, input logic [31:0] b);
      return longint'($signed(a)) * longint'($signed(b));
   endfunction

   function automatic logic ref_ovf(input longint p);
      logic [31:0] lo;
      lo = p[31:0];
      return (p != longint'($signed(lo)));
   endfunction

   // Drives start for one cycle; returns at the falling edge after the sampling edge.
   task automatic do_start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      start = 1'b1; A_in = a; B_in = b;
      @(negedge clock);
      start = 1'b0;
   endtask

   // One full operation from idle with latency, hold and result checks.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
      longint      p;
      logic [31:0] eo;
      logic        ee;
      logic [31:0] held;
      int          lat;
      bit          moved;
      p     = ref_prod(a, b);
      eo    = p[31:0];
      ee    = ref_ovf(p);
      held  = out;
      moved = 1'b0;
      do_start(a, b);
      lat = 0;
      while (!ready && lat < 40) begin
         if (out !== held) moved = 1'b1;
         @(negedge clock);
         lat++;
      end
      checks++;
      if (lat !== 16) begin
         failures++;
         $display("FAIL %s latency got=%0d want=16", tag, lat);
      end
      checks++;
      if (out !== eo) begin
         failures++;
         $display("FAIL %s out got=%h want=%h (a=%h b=%h)", tag, out, eo, a, b);
      end
      checks++;
      if (exp !== ee) begin
         failures++;
         $display("FAIL %s exp got=%b want=%b (a=%h b=%h)", tag, exp, ee, a, b);
      end
      checks++;
      if (moved) begin
         failures++;
         $display("FAIL %s out changed while busy, want held=%h", tag, held);
      end
      @(negedge clock);
      checks++;
      if (ready !== 1'b0 || out !== eo) begin
         failures++;
         $display("FAIL %s after-done ready=%b out=%h want ready=0 out=%h", tag, ready, out, eo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; A_in = '0; B_in = '0;
      #3;
      checks++;
      if (out !== 32'h0 || exp !== 1'b0 || ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_values out=%h exp=%b ready=%b want 0/0/0", out, exp, ready);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready got=%b want=0", ready);
      end
   endtask

   task automatic test_directed();
      run_op(32'd3, 32'd4, "3x4");
      checks++;
      if (out !== 32'h0000000C) begin
         failures++;
         $display("FAIL 3x4_const out=%h want=0000000c", out);
      end
      run_op(32'hFFFFFFF9, 32'd6, "m7x6");
      run_op(32'h7FFFFFFF, 32'd1, "max_x1");
      run_op(32'h00010000, 32'h00010000, "2p16sq");
      run_op(32'h80000000, 32'hFFFFFFFF, "min_xm1");
      checks++;
      if (out !== 32'h80000000 || exp !== 1'b1) begin
         failures++;
         $display("FAIL min_xm1_const out=%h exp=%b want 80000000/1", out, exp);
      end
      run_op(32'h0, $urandom, "zero_a");
      run_op($urandom, 32'h0, "zero_b");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: a = 32'h80000000;
            1: a = 32'h7FFFFFFF;
            2: a = $urandom_range(0, 255) - 128;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0: b = 32'hFFFFFFFF;
            1: b = $urandom_range(0, 65535);
            default: b = $urandom;
         endcase
         run_op(a, b, "random");
      end
   endtask

   task automatic test_abort();
      int nready;
      int first;
      do_start(32'd5, 32'd5);
      repeat (6) @(negedge clock);
      do_start(32'd2, 32'd9);
      nready = 0;
      first  = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clock);
         if (ready) begin
            nready++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (nready !== 1) begin
         failures++;
         $display("FAIL abort_ready_count got=%0d want=1", nready);
      end
      checks++;
      if (first !== 16) begin
         failures++;
         $display("FAIL abort_latency got=%0d want=16", first);
      end
      checks++;
      if (out !== 32'd18 || exp !== 1'b0) begin
         failures++;
         $display("FAIL abort_result out=%h exp=%b want 00000012/0", out, exp);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      do_start(32'd5, 32'd7);
      repeat (6) @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out !== 32'h0 || exp !== 1'b0 || ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid out=%h exp=%b ready=%b want 0/0/0", out, exp, ready);
      end
      @(negedge clock);
      reset = 1'b0;
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "after_reset");
      checks++;
      if (out !== 32'd1) begin
         failures++;
         $display("FAIL after_reset_const out=%h want=00000001", out);
      end
      // Reset landing in the ready cycle clears the pulse and result at once.
      do_start(32'd3, 32'd3);
      lat = 0;
      while (!ready && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (lat !== 16 || ready !== 1'b0 || out !== 32'h0) begin
         failures++;
         $display("FAIL reset_in_done lat=%0d ready=%b out=%h want 16/0/0", lat, ready, out);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2, e1, e2;
      logic        x2;
      longint      p;
      int          lat;
      bit          moved;
      a1 = $urandom; b1 = $urandom_range(1, 1000);
      a2 = $urandom; b2 = $urandom;
      p  = ref_prod(a1, b1); e1 = p[31:0];
      p  = ref_prod(a2, b2); e2 = p[31:0]; x2 = ref_ovf(p);
      do_start(a1, b1);
      lat = 0;
      while (!ready && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      checks++;
      if (lat !== 16 || out !== e1) begin
         failures++;
         $display("FAIL b2b_first lat=%0d out=%h want 16/%h", lat, out, e1);
      end
      // Re-issue start during the ready cycle.
      start = 1'b1; A_in = a2; B_in = b2;
      @(negedge clock);
      start = 1'b0;
      lat   = 0;
      moved = 1'b0;
      while (!ready && lat < 40) begin
         if (out !== e1) moved = 1'b1;
         @(negedge clock);
         lat++;
      end
      checks++;
      if (lat !== 16) begin
         failures++;
         $display("FAIL b2b_second_latency got=%0d want=16", lat);
      end
      checks++;
      if (moved) begin
         failures++;
         $display("FAIL b2b_hold out left first result %h before second ready", e1);
      end
      checks++;
      if (out !== e2 || exp !== x2) begin
         failures++;
         $display("FAIL b2b_second out=%h exp=%b want %h/%b", out, exp, e2, x2);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
